// File: rtl/rf_pkg.sv
// Shared widths and types for the RV32I integer register file.
// The top module and the scoreboard take their parameter defaults from here.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_NUMBER = 32;
  localparam int AW         = $clog2(REG_NUMBER);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the register file.
// master = pipeline side, slave = register file.
interface reg_file_sb_if #(
  parameter int XLEN       = rf_pkg::XLEN,
  parameter int REG_NUMBER = rf_pkg::REG_NUMBER,
  parameter int READ_PORTS = 2
);
  localparam int AW = $clog2(REG_NUMBER);

  logic [READ_PORTS*AW-1:0]   raddr;
  logic [READ_PORTS*XLEN-1:0] rdata;
  logic [READ_PORTS-1:0]      rbusy;
  logic                       alloc_valid;
  logic [AW-1:0]              alloc_addr;
  logic                       alloc_ready;
  logic                       write;
  logic [AW-1:0]              waddr;
  logic [XLEN-1:0]            wdata;
  logic [AW:0]                pending_cnt;

  modport master (
    output raddr, alloc_valid, alloc_addr, write, waddr, wdata,
    input  rdata, rbusy, alloc_ready, pending_cnt
  );

  modport slave (
    input  raddr, alloc_valid, alloc_addr, write, waddr, wdata,
    output rdata, rbusy, alloc_ready, pending_cnt
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: alloc handshake, busy clear on writeback,
// and a count of registers awaiting a write.
module rf_scoreboard #(
  parameter int REG_NUMBER = rf_pkg::REG_NUMBER,
  localparam int AW        = $clog2(REG_NUMBER)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_valid,
  input  logic [AW-1:0]         alloc_addr,
  input  logic                  write,
  input  logic [AW-1:0]         waddr,
  output logic [REG_NUMBER-1:0] busy,
  output logic                  alloc_ready,
  output logic [AW:0]           pending_cnt
);
  import rf_pkg::*;

  localparam logic [AW-1:0] X0 = AW'(ZERO_REG);

  logic                  alloc_acc;
  logic                  busy_clr;
  logic                  inc;
  logic                  dec;
  logic [REG_NUMBER-1:0] busy_nxt;

  // A writeback in flight to alloc_addr frees it this cycle, so the alloc may proceed.
  assign alloc_ready = (alloc_addr == X0) | ~busy[alloc_addr]
                     | (write && (waddr == alloc_addr));
  assign alloc_acc   = alloc_valid & alloc_ready & (alloc_addr != X0);
  assign busy_clr    = write && (waddr != X0) && busy[waddr];
  assign inc         = alloc_acc & ~busy[alloc_addr];
  assign dec         = busy_clr & ~(alloc_acc && (alloc_addr == waddr));

  always_comb begin
    busy_nxt = busy;
    if (busy_clr)  busy_nxt[waddr]      = 1'b0;
    if (alloc_acc) busy_nxt[alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      case ({inc, dec})
        2'b10:   pending_cnt <= pending_cnt + 1'b1;
        2'b01:   pending_cnt <= pending_cnt - 1'b1;
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with write-to-read bypass,
// x0 hardwired to zero, and a busy scoreboard for decode stalls.
module reg_file_sb #(
  parameter int XLEN       = rf_pkg::XLEN,
  parameter int REG_NUMBER = rf_pkg::REG_NUMBER,
  parameter int READ_PORTS = 2
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_sb_if.slave  bus
);
  import rf_pkg::*;

  localparam int            AW = $clog2(REG_NUMBER);
  localparam logic [AW-1:0] X0 = AW'(ZERO_REG);

  logic [XLEN-1:0]       regs [REG_NUMBER];
  logic [REG_NUMBER-1:0] busy;
  logic                  wr_en;
  logic [AW-1:0]         ra;

  assign wr_en = bus.write && (bus.waddr != X0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_NUMBER; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // x0 reads as zero; a same-cycle writeback is forwarded and hides the busy bit.
  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    ra        = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      ra = bus.raddr[p*AW +: AW];
      if (ra == X0)
        bus.rdata[p*XLEN +: XLEN] = '0;
      else if (bus.write && (bus.waddr == ra))
        bus.rdata[p*XLEN +: XLEN] = bus.wdata;
      else
        bus.rdata[p*XLEN +: XLEN] = regs[ra];
      bus.rbusy[p] = busy[ra] & ~(bus.write && (bus.waddr == ra));
    end
  end

  rf_scoreboard #(.REG_NUMBER(REG_NUMBER)) u_sb (
    .clk         (clk),
    .reset       (reset),
    .alloc_valid (bus.alloc_valid),
    .alloc_addr  (bus.alloc_addr),
    .write       (bus.write),
    .waddr       (bus.waddr),
    .busy        (busy),
    .alloc_ready (bus.alloc_ready),
    .pending_cnt (bus.pending_cnt)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an array-based model.
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int RN   = 32;
  localparam int RP   = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic reset;
  logic chk_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  reg_file_sb_if #(.XLEN(XLEN), .REG_NUMBER(RN), .READ_PORTS(RP)) bus ();

  reg_file_sb #(.XLEN(XLEN), .REG_NUMBER(RN), .READ_PORTS(RP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Architectural model: plain arrays updated by the rules at each edge.
  logic [XLEN-1:0] m_regs [RN];
  bit              m_busy [RN];

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < RN; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic bit m_ready();
    return (bus.alloc_addr == 0) || !m_busy[bus.alloc_addr]
        || (bus.write && bus.waddr == bus.alloc_addr);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RN; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      automatic bit acc = bus.alloc_valid && m_ready() && bus.alloc_addr != 0;
      if (bus.write && bus.waddr != 0) begin
        m_regs[bus.waddr] = bus.wdata;
        m_busy[bus.waddr] = 1'b0;
      end
      if (acc) m_busy[bus.alloc_addr] = 1'b1;
    end
  end

  logic [AW-1:0]   c_ra;
  logic [XLEN-1:0] c_d;
  bit              c_b;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < RP; p++) begin
        c_ra = bus.raddr[p*AW +: AW];
        c_b  = 1'b0;
        if (c_ra == 0) c_d = '0;
        else if (bus.write && bus.waddr == c_ra) c_d = bus.wdata;
        else begin
          c_d = m_regs[c_ra];
          c_b = m_busy[c_ra];
        end
        check($sformatf("model rdata%0d x%0d", p, c_ra), 64'(bus.rdata[p*XLEN +: XLEN]), 64'(c_d));
        check($sformatf("model rbusy%0d x%0d", p, c_ra), 64'(bus.rbusy[p]), 64'(c_b));
      end
      check("model alloc_ready", 64'(bus.alloc_ready), 64'(m_ready()));
      check("model pending_cnt", 64'(bus.pending_cnt), 64'(m_pending()));
    end
  end

  task automatic idle();
    bus.raddr       = '0;
    bus.alloc_valid = 1'b0;
    bus.alloc_addr  = '0;
    bus.write       = 1'b0;
    bus.waddr       = '0;
    bus.wdata       = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raddr(input int p, input int a);
    bus.raddr[p*AW +: AW] = AW'(a);
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, RN-1));
    return int'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_en = 1'b1;

    // 1: everything reads zero and idle after reset
    for (int r = 0; r < RN; r += 2) begin
      set_raddr(0, r);
      set_raddr(1, r + 1);
      @(negedge clk);
      check("reset rdata0", 64'(bus.rdata[0 +: XLEN]), 64'h0);
      check("reset rdata1", 64'(bus.rdata[XLEN +: XLEN]), 64'h0);
      check("reset rbusy", 64'(bus.rbusy), 64'h0);
      check("reset pending", 64'(bus.pending_cnt), 64'h0);
      step();
    end

    // 2: registered write then bypassed write
    idle();
    bus.write = 1'b1; bus.waddr = 5'd26; bus.wdata = 32'h1;
    step();
    bus.waddr = 5'd2; bus.wdata = 32'hF;
    set_raddr(0, 26); set_raddr(1, 2);
    @(negedge clk);
    check("x26 readback", 64'(bus.rdata[0 +: XLEN]), 64'h1);
    check("x2 bypass", 64'(bus.rdata[XLEN +: XLEN]), 64'hF);
    step();

    // 3: x0 is immune to writes and allocs
    idle();
    bus.write = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hA;
    step();
    idle();
    bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd0;
    @(negedge clk);
    check("x0 read", 64'(bus.rdata[0 +: XLEN]), 64'h0);
    check("x0 alloc ready", 64'(bus.alloc_ready), 64'h1);
    step();
    idle();
    @(negedge clk);
    check("x0 alloc pending", 64'(bus.pending_cnt), 64'h0);
    step();

    // 4: alloc, WAW stall, writeback clears
    bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd5;
    @(negedge clk);
    check("x5 alloc ready", 64'(bus.alloc_ready), 64'h1);
    step();
    set_raddr(0, 5);
    @(negedge clk);
    check("x5 rbusy", 64'(bus.rbusy[0]), 64'h1);
    check("x5 pending 1", 64'(bus.pending_cnt), 64'h1);
    check("x5 realloc ready", 64'(bus.alloc_ready), 64'h0);
    step();
    @(negedge clk);
    check("x5 stall pending", 64'(bus.pending_cnt), 64'h1);
    bus.alloc_valid = 1'b0;
    bus.write = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h55;
    @(negedge clk);
    check("x5 wb rbusy", 64'(bus.rbusy[0]), 64'h0);
    check("x5 wb bypass", 64'(bus.rdata[0 +: XLEN]), 64'h55);
    step();
    bus.write = 1'b0;
    @(negedge clk);
    check("x5 cleared pending", 64'(bus.pending_cnt), 64'h0);
    check("x5 stored", 64'(bus.rdata[0 +: XLEN]), 64'h55);
    step();

    // 5: simultaneous writeback and alloc of the same busy register
    idle();
    bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd7;
    step();
    bus.write = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h77;
    @(negedge clk);
    check("x7 ready on wb", 64'(bus.alloc_ready), 64'h1);
    check("x7 pending before", 64'(bus.pending_cnt), 64'h1);
    step();
    idle();
    set_raddr(0, 7);
    @(negedge clk);
    check("x7 data", 64'(bus.rdata[0 +: XLEN]), 64'h77);
    check("x7 still busy", 64'(bus.rbusy[0]), 64'h1);
    check("x7 pending after", 64'(bus.pending_cnt), 64'h1);
    step();

    // 6: mid-stream reset discards everything
    for (int r = 1; r <= 4; r++) begin
      bus.alloc_valid = 1'b1; bus.alloc_addr = AW'(r);
      step();
    end
    idle();
    @(negedge clk);
    check("pre-reset pending", 64'(bus.pending_cnt), 64'h5);
    bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd9;
    bus.write = 1'b1; bus.waddr = 5'd12; bus.wdata = 32'hDEAD;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    set_raddr(0, 26); set_raddr(1, 7);
    @(negedge clk);
    check("post-reset x26", 64'(bus.rdata[0 +: XLEN]), 64'h0);
    check("post-reset x7 busy", 64'(bus.rbusy[1]), 64'h0);
    check("post-reset pending", 64'(bus.pending_cnt), 64'h0);
    step();
    set_raddr(0, 12); set_raddr(1, 3);
    @(negedge clk);
    check("post-reset x12", 64'(bus.rdata[0 +: XLEN]), 64'h0);
    check("post-reset x3 busy", 64'(bus.rbusy[1]), 64'h0);
    step();

    // Randomized traffic with collisions biased onto low registers
    for (int c = 0; c < 4000; c++) begin
      reset           = ($urandom_range(0, 299) == 0);
      bus.alloc_valid = ($urandom_range(0, 1) == 1);
      bus.alloc_addr  = AW'(pick_addr());
      bus.write       = ($urandom_range(0, 2) != 0);
      bus.waddr       = AW'(pick_addr());
      bus.wdata       = $urandom;
      for (int p = 0; p < RP; p++) begin
        case ($urandom_range(0, 3))
          0:       set_raddr(p, int'(bus.waddr));
          1:       set_raddr(p, int'(bus.alloc_addr));
          default: set_raddr(p, pick_addr());
        endcase
      end
      step();
    end

    reset = 1'b0;
    idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
